// File: rtl/inst_sequencer_if.sv
// Instruction-memory fetch channel: one outstanding request,
// address held while waiting for the data-valid strobe.
interface inst_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/inst_sequencer.sv
// Multi-cycle RV32E control sequencer: FETCH -> EXEC -> WB,
// with a sticky HALT state reporting why the core stopped.
module inst_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  inst_sequencer_if.master imem,
  output logic [31:0]      inst,
  input  logic             dec_ebreak,
  input  logic             dec_illegal,
  input  logic             dec_rf_wen,
  input  logic [31:0]      next_pc,
  output logic [31:0]      pc,
  output logic             rf_we,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [2:0]       halt_code
);

  localparam int unsigned TW = $clog2(FETCH_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    HC_NONE     = 3'd0,
    HC_EBREAK   = 3'd1,
    HC_ILLEGAL  = 3'd2,
    HC_TIMEOUT  = 3'd3,
    HC_MISALIGN = 3'd4
  } hcode_e;

  state_e             state_q, state_d;
  hcode_e             code_q, code_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        inst_q, inst_d;
  logic [CNT_W-1:0]   ret_q, ret_d;
  logic [TW-1:0]      tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      code_q  <= HC_NONE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      ret_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ret_q   <= ret_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    ret_d         = ret_q;
    tmo_d         = tmo_q;
    imem.imem_req = 1'b0;
    rf_we         = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem.imem_req = 1'b1;
        // data arriving on the last allowed cycle still counts
        if (imem.imem_rvalid) begin
          inst_d  = imem.imem_rdata;
          tmo_d   = '0;
          state_d = S_EXEC;
        end else if (tmo_q == TO_LAST) begin
          code_d  = HC_TIMEOUT;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_EXEC: begin
        if (dec_ebreak) begin
          code_d  = HC_EBREAK;
          state_d = S_HALT;
        end else if (dec_illegal) begin
          code_d  = HC_ILLEGAL;
          state_d = S_HALT;
        end else if (next_pc[1:0] != 2'b00) begin
          code_d  = HC_MISALIGN;
          state_d = S_HALT;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we   = dec_rf_wen;
        pc_d    = next_pc;
        ret_d   = ret_q + CNT_W'(1);
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign instret        = ret_q;
  assign halted         = (state_q == S_HALT);
  assign halt_code      = code_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: per-cycle timeline model of each
// scripted instruction plus hand-computed checkpoints.
module tb_inst_sequencer;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int FT = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  typedef struct {
    int          d;
    logic [31:0] rdata;
    bit          eb;
    bit          il;
    bit          wen;
    logic [31:0] npc;
  } ins_t;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        dec_ebreak;
  logic        dec_illegal;
  logic        dec_rf_wen;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        rf_we;
  logic [31:0] instret;
  logic        halted;
  logic [2:0]  halt_code;

  inst_sequencer_if ifc();

  inst_sequencer #(
    .RESET_PC(RPC),
    .FETCH_TIMEOUT(FT),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem(ifc),
    .inst(inst),
    .dec_ebreak(dec_ebreak),
    .dec_illegal(dec_illegal),
    .dec_rf_wen(dec_rf_wen),
    .next_pc(next_pc),
    .pc(pc),
    .rf_we(rf_we),
    .instret(instret),
    .halted(halted),
    .halt_code(halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k;
  int cyc;
  int rst_at;
  int we_cnt;
  ins_t scr[$];

  logic        e_req, e_we, e_hlt;
  logic [2:0]  e_code;
  logic [31:0] e_pc, e_inst, e_ret;
  logic        d_rv, d_eb, d_il, d_wen;
  logic [31:0] d_rd, d_npc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  task automatic add(input int d, input logic [31:0] rd,
                     input bit eb, input bit il, input bit wen,
                     input logic [31:0] npc);
    ins_t t;
    t.d = d; t.rdata = rd; t.eb = eb;
    t.il = il; t.wen = wen; t.npc = npc;
    scr.push_back(t);
  endtask

  // Cycle k (1 = first cycle after reset): instruction i starts at s,
  // fetches for d+1 cycles, then EXEC, then WB, next starts at s+d+3.
  task automatic model(input int kk);
    int s, r, i, d;
    bit fin;
    logic [31:0] p, in;
    logic [2:0] code;
    s = 1; r = 0; i = 0; fin = 0;
    p = RPC; in = NOP;
    e_req = 0; e_we = 0; e_hlt = 0; e_code = 0;
    d_rv = (kk % 3 == 0);
    d_rd = 32'hDEAD_0000 | 32'(kk);
    d_eb = 0; d_il = 0; d_wen = 1; d_npc = 32'hFFFF_FFF2;
    while (!fin) begin
      if (i >= scr.size() || scr[i].d >= FT) begin
        fin = 1;
        if (kk < s + FT) begin
          e_req = 1; d_rv = 0;
        end else begin
          e_hlt = 1; e_code = 3;
        end
      end else if (kk <= s + scr[i].d) begin
        fin = 1; e_req = 1;
        d_rv = (kk == s + scr[i].d);
        if (d_rv) d_rd = scr[i].rdata;
      end else begin
        d = scr[i].d;
        in = scr[i].rdata;
        d_eb = scr[i].eb; d_il = scr[i].il;
        d_wen = scr[i].wen; d_npc = scr[i].npc;
        code = scr[i].eb ? 3'd1 : scr[i].il ? 3'd2 :
               (scr[i].npc[1:0] != 2'b00) ? 3'd4 : 3'd0;
        if (kk == s + d + 1) begin
          fin = 1;
        end else if (code != 0) begin
          fin = 1; e_hlt = 1; e_code = code;
        end else if (kk == s + d + 2) begin
          fin = 1; e_we = scr[i].wen;
        end else begin
          p = scr[i].npc; r++; s += d + 3; i++;
        end
      end
    end
    e_pc = p; e_ret = 32'(r); e_inst = in;
  endtask

  task automatic start();
    @(negedge clk);
    rst = 1;
    ifc.imem_rvalid = 1;
    ifc.imem_rdata = 32'h00A0_0093;
    repeat (2) @(posedge clk);
    k = 0; cyc = 0; rst_at = 0; we_cnt = 0;
  endtask

  task automatic step();
    @(negedge clk);
    rst = 0;
    k++; cyc++;
    model(k);
    ifc.imem_rvalid = d_rv;
    ifc.imem_rdata = d_rd;
    dec_ebreak = d_eb;
    dec_illegal = d_il;
    dec_rf_wen = d_wen;
    next_pc = d_npc;
    if (cyc == rst_at) begin
      rst = 1;
      ifc.imem_rvalid = 1;
    end
    #2;
    chk("imem_req", 32'(ifc.imem_req), 32'(e_req));
    chk("imem_addr", ifc.imem_addr, e_pc);
    chk("pc", pc, e_pc);
    chk("inst", inst, e_inst);
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("instret", instret, e_ret);
    chk("halted", 32'(halted), 32'(e_hlt));
    chk("halt_code", 32'(halt_code), 32'(e_code));
    we_cnt += int'(rf_we);
    if (cyc == rst_at) k = 0;
  endtask

  initial begin
    rst = 1;
    ifc.imem_rvalid = 0; ifc.imem_rdata = 0;
    dec_ebreak = 0; dec_illegal = 0; dec_rf_wen = 0;
    next_pc = 0;

    // addi x1,x0,5 with immediate data
    scr.delete();
    add(0, 32'h0050_0093, 0, 0, 1, RPC + 4);
    add(0, EBRK, 1, 0, 0, RPC + 8);
    start();
    step();
    chk("s1_reset_pc", pc, RPC);
    chk("s1_reset_inst", inst, NOP);
    step(); step();
    chk("s1_we_c3", 32'(rf_we), 32'd1);
    step();
    chk("s1_pc_c4", pc, 32'h8000_0004);
    chk("s1_ret_c4", instret, 32'd1);
    chk("s1_req_c4", 32'(ifc.imem_req), 32'd1);
    repeat (2) step();
    chk("s1_we_once", 32'(we_cnt), 32'd1);

    // rvalid delays 0, 2, 5
    scr.delete();
    add(0, 32'h0050_0093, 0, 0, 1, RPC + 4);
    add(2, 32'h0000_0097, 0, 0, 1, RPC + 8);
    add(5, 32'h0010_8113, 0, 0, 1, RPC + 12);
    add(0, EBRK, 1, 0, 0, RPC + 16);
    start();
    repeat (10) step();
    chk("s2_addr_wait", ifc.imem_addr, 32'h8000_0008);
    repeat (7) step();
    chk("s2_pc_c17", pc, 32'h8000_000C);
    chk("s2_ret_c17", instret, 32'd3);
    repeat (3) step();

    // ebreak at 8000_0008, later rvalid pulses ignored
    scr.delete();
    add(0, 32'h0050_0093, 0, 0, 1, RPC + 4);
    add(0, 32'h0000_0097, 0, 0, 1, RPC + 8);
    add(1, EBRK, 1, 0, 1, RPC + 12);
    start();
    repeat (20) step();
    chk("s3_halted", 32'(halted), 32'd1);
    chk("s3_code", 32'(halt_code), 32'd1);
    chk("s3_pc", pc, 32'h8000_0008);
    chk("s3_inst", inst, EBRK);
    chk("s3_ret", instret, 32'd2);
    chk("s3_we_cnt", 32'(we_cnt), 32'd2);

    // illegal
    scr.delete();
    add(0, 32'hFFFF_FFFF, 0, 1, 1, RPC + 4);
    start();
    repeat (5) step();
    chk("s4_code", 32'(halt_code), 32'd2);
    chk("s4_ret", instret, 32'd0);

    // ebreak and illegal together
    scr.delete();
    add(0, EBRK, 1, 1, 0, RPC + 4);
    start();
    repeat (5) step();
    chk("s5_code", 32'(halt_code), 32'd1);

    // fetch timeout
    scr.delete();
    start();
    repeat (16) step();
    chk("s6_c16_run", 32'(halted), 32'd0);
    chk("s6_c16_req", 32'(ifc.imem_req), 32'd1);
    step();
    chk("s6_c17_halt", 32'(halted), 32'd1);
    chk("s6_c17_code", 32'(halt_code), 32'd3);
    step();

    // rvalid on the last allowed fetch cycle
    scr.delete();
    add(15, 32'h0050_0093, 0, 0, 1, RPC + 4);
    add(0, EBRK, 1, 0, 0, RPC + 8);
    start();
    repeat (17) step();
    chk("s7_c17_run", 32'(halted), 32'd0);
    step();
    chk("s7_c18_we", 32'(rf_we), 32'd1);
    repeat (4) step();
    chk("s7_ret", instret, 32'd1);
    chk("s7_code", 32'(halt_code), 32'd1);

    // misaligned next_pc
    scr.delete();
    add(0, 32'h0050_0093, 0, 0, 1, RPC + 4);
    add(0, 32'h0000_0097, 0, 0, 1, 32'h8000_0006);
    start();
    repeat (7) step();
    chk("s8_code", 32'(halt_code), 32'd4);
    chk("s8_ret", instret, 32'd1);
    chk("s8_pc", pc, 32'h8000_0004);

    // reset during WB
    scr.delete();
    add(1, 32'h0050_0093, 0, 0, 1, RPC + 4);
    add(0, EBRK, 1, 0, 0, RPC + 8);
    start();
    rst_at = 4;
    repeat (4) step();
    chk("s9_wb_we", 32'(rf_we), 32'd1);
    step();
    chk("s9_pc", pc, RPC);
    chk("s9_ret", instret, 32'd0);
    chk("s9_we", 32'(rf_we), 32'd0);
    chk("s9_halted", 32'(halted), 32'd0);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
